// File: rtl/stage_mem.sv
// Memory-access pipeline stage: runs word loads/stores over a request/grant/ready bus,
// flags misaligned accesses and drives the MEM/WB pipeline register plus a forwarding value.
module stage_mem #(
    parameter int unsigned WORD         = 32,
    parameter int unsigned ADDR_W       = 30,
    parameter logic [2:0]  EXP_MISALIGN = 3'd4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] ex_pc,
    input  logic              ex_en,
    input  logic              ex_br_flag,
    input  logic [1:0]        ex_mem_op,
    input  logic [WORD-1:0]   ex_mem_wr_data,
    input  logic [1:0]        ex_ctrl_op,
    input  logic [4:0]        ex_dst_addr,
    input  logic              ex_gpr_we_,
    input  logic [2:0]        ex_exp_code,
    input  logic [WORD-1:0]   ex_out,
    output logic              bus_req,
    input  logic              bus_grant,
    output logic              bus_as,
    output logic              bus_rw,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [WORD-1:0]   bus_wr_data,
    input  logic [WORD-1:0]   bus_rd_data,
    input  logic              bus_rdy,
    output logic              busy,
    output logic [WORD-1:0]   fwd_data,
    output logic [ADDR_W-1:0] mem_pc,
    output logic              mem_en,
    output logic              mem_br_flag,
    output logic [1:0]        mem_ctrl_op,
    output logic [4:0]        mem_dst_addr,
    output logic              mem_gpr_we_,
    output logic [2:0]        mem_exp_code,
    output logic [WORD-1:0]   mem_out
);

    localparam logic [1:0] MemLoad  = 2'd1;
    localparam logic [1:0] MemStore = 2'd2;

    typedef enum logic [2:0] {StIdle, StReq, StAccess, StWait, StDone} state_e;

    state_e            state_q, state_d;
    logic              flush_pending_q, flush_pending_d;
    logic [WORD-1:0]   rd_data_q, rd_data_d;

    logic [ADDR_W-1:0] mem_pc_q, mem_pc_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_br_flag_q, mem_br_flag_d;
    logic [1:0]        mem_ctrl_op_q, mem_ctrl_op_d;
    logic [4:0]        mem_dst_addr_q, mem_dst_addr_d;
    logic              mem_gpr_we_q, mem_gpr_we_d;
    logic [2:0]        mem_exp_code_q, mem_exp_code_d;
    logic [WORD-1:0]   mem_out_q, mem_out_d;

    logic              is_mem_op;
    logic              need_access;
    logic              misalign;
    logic              load_en;
    logic              from_bus;
    logic              in_txn;
    logic [WORD-1:0]   load_data;

    logic [ADDR_W-1:0] nxt_pc;
    logic              nxt_en;
    logic              nxt_br_flag;
    logic [1:0]        nxt_ctrl_op;
    logic [4:0]        nxt_dst_addr;
    logic              nxt_gpr_we_;
    logic [2:0]        nxt_exp_code;
    logic [WORD-1:0]   nxt_out;

    assign is_mem_op   = (ex_mem_op == MemLoad) || (ex_mem_op == MemStore);
    assign need_access = ex_en & is_mem_op & (ex_exp_code == 3'd0) & (ex_out[1:0] == 2'b00)
                         & ~flush;
    assign misalign    = ex_en & is_mem_op & (ex_exp_code == 3'd0) & (ex_out[1:0] != 2'b00);

    // The upstream stage is held by busy, so ex_* stays stable for the whole transaction.
    assign bus_rw      = (ex_mem_op == MemLoad);
    assign bus_addr    = ex_out[WORD-1:2];
    assign bus_wr_data = ex_mem_wr_data;

    assign from_bus  = (state_q == StWait) || (state_q == StDone);
    assign in_txn    = (state_q == StAccess) || (state_q == StWait) || (state_q == StDone);
    assign load_data = (state_q == StWait) ? bus_rd_data : rd_data_q;

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        bus_req = 1'b0;
        bus_as  = 1'b0;
        load_en = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (need_access) begin
                    busy    = 1'b1;
                    state_d = StReq;
                end else begin
                    load_en = ~stall;
                end
            end
            StReq: begin
                if (flush) begin
                    state_d = StIdle;
                    load_en = ~stall;
                end else begin
                    bus_req = 1'b1;
                    busy    = 1'b1;
                    if (bus_grant) begin
                        state_d = StAccess;
                    end
                end
            end
            StAccess: begin
                bus_req = 1'b1;
                bus_as  = 1'b1;
                busy    = 1'b1;
                state_d = StWait;
            end
            StWait: begin
                bus_req = 1'b1;
                if (bus_rdy) begin
                    if (stall) begin
                        state_d = StDone;
                    end else begin
                        load_en = 1'b1;
                        state_d = StIdle;
                    end
                end else begin
                    busy = 1'b1;
                end
            end
            StDone: begin
                if (!stall) begin
                    load_en = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // A flush seen once the bus is committed must still discard the eventual result.
    always_comb begin
        flush_pending_d = flush_pending_q | (flush & in_txn);
        if (state_d == StIdle) begin
            flush_pending_d = 1'b0;
        end
        rd_data_d = rd_data_q;
        if ((state_q == StWait) && bus_rdy) begin
            rd_data_d = bus_rd_data;
        end
    end

    always_comb begin
        nxt_pc       = '0;
        nxt_en       = 1'b0;
        nxt_br_flag  = 1'b0;
        nxt_ctrl_op  = 2'd0;
        nxt_dst_addr = 5'd0;
        nxt_gpr_we_  = 1'b1;
        nxt_exp_code = 3'd0;
        nxt_out      = '0;
        if (flush || flush_pending_q) begin
            nxt_gpr_we_ = 1'b1;
        end else if (misalign) begin
            nxt_pc       = ex_pc;
            nxt_en       = ex_en;
            nxt_br_flag  = ex_br_flag;
            nxt_exp_code = EXP_MISALIGN;
        end else begin
            nxt_pc       = ex_pc;
            nxt_en       = ex_en;
            nxt_br_flag  = ex_br_flag;
            nxt_ctrl_op  = ex_ctrl_op;
            nxt_dst_addr = ex_dst_addr;
            nxt_gpr_we_  = ex_gpr_we_;
            nxt_exp_code = ex_exp_code;
            nxt_out      = (from_bus && (ex_mem_op == MemLoad)) ? load_data : ex_out;
        end
    end

    always_comb begin
        mem_pc_d       = mem_pc_q;
        mem_en_d       = mem_en_q;
        mem_br_flag_d  = mem_br_flag_q;
        mem_ctrl_op_d  = mem_ctrl_op_q;
        mem_dst_addr_d = mem_dst_addr_q;
        mem_gpr_we_d   = mem_gpr_we_q;
        mem_exp_code_d = mem_exp_code_q;
        mem_out_d      = mem_out_q;
        if (load_en) begin
            mem_pc_d       = nxt_pc;
            mem_en_d       = nxt_en;
            mem_br_flag_d  = nxt_br_flag;
            mem_ctrl_op_d  = nxt_ctrl_op;
            mem_dst_addr_d = nxt_dst_addr;
            mem_gpr_we_d   = nxt_gpr_we_;
            mem_exp_code_d = nxt_exp_code;
            mem_out_d      = nxt_out;
        end
    end

    assign fwd_data = mem_out_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= StIdle;
            flush_pending_q <= 1'b0;
            rd_data_q       <= '0;
            mem_pc_q        <= '0;
            mem_en_q        <= 1'b0;
            mem_br_flag_q   <= 1'b0;
            mem_ctrl_op_q   <= 2'd0;
            mem_dst_addr_q  <= 5'd0;
            mem_gpr_we_q    <= 1'b1;
            mem_exp_code_q  <= 3'd0;
            mem_out_q       <= '0;
        end else begin
            state_q         <= state_d;
            flush_pending_q <= flush_pending_d;
            rd_data_q       <= rd_data_d;
            mem_pc_q        <= mem_pc_d;
            mem_en_q        <= mem_en_d;
            mem_br_flag_q   <= mem_br_flag_d;
            mem_ctrl_op_q   <= mem_ctrl_op_d;
            mem_dst_addr_q  <= mem_dst_addr_d;
            mem_gpr_we_q    <= mem_gpr_we_d;
            mem_exp_code_q  <= mem_exp_code_d;
            mem_out_q       <= mem_out_d;
        end
    end

    assign mem_pc       = mem_pc_q;
    assign mem_en       = mem_en_q;
    assign mem_br_flag  = mem_br_flag_q;
    assign mem_ctrl_op  = mem_ctrl_op_q;
    assign mem_dst_addr = mem_dst_addr_q;
    assign mem_gpr_we_  = mem_gpr_we_q;
    assign mem_exp_code = mem_exp_code_q;
    assign mem_out      = mem_out_q;

endmodule

// File: tb/tb_stage_mem.sv
// Bench for stage_mem: table of single-cycle vectors plus hand-written bus sequences,
// with expected MEM/WB records queued at drive time and popped when the register loads.
module tb_stage_mem;

    typedef struct packed {
        logic [29:0] pc;
        logic        en;
        logic        br;
        logic [1:0]  ctrl;
        logic [4:0]  dst;
        logic        we_;
        logic [2:0]  exp;
        logic [31:0] out;
    } rec_t;

    typedef struct {
        logic [29:0] pc;
        logic        en;
        logic        br;
        logic [1:0]  op;
        logic [1:0]  ctrl;
        logic [4:0]  dst;
        logic        we_;
        logic [2:0]  ec;
        logic [31:0] a;
        logic        fl;
        logic        st;
        rec_t        e;
        logic        ebusy;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset, stall, flush;
    logic [29:0] ex_pc;
    logic        ex_en, ex_br_flag;
    logic [1:0]  ex_mem_op, ex_ctrl_op;
    logic [31:0] ex_mem_wr_data, ex_out;
    logic [4:0]  ex_dst_addr;
    logic        ex_gpr_we_;
    logic [2:0]  ex_exp_code;
    logic        bus_req, bus_grant, bus_as, bus_rw, bus_rdy, busy;
    logic [29:0] bus_addr;
    logic [31:0] bus_wr_data, bus_rd_data, fwd_data;
    logic [29:0] mem_pc;
    logic        mem_en, mem_br_flag, mem_gpr_we_;
    logic [1:0]  mem_ctrl_op;
    logic [4:0]  mem_dst_addr;
    logic [2:0]  mem_exp_code;
    logic [31:0] mem_out;

    int   n_chk = 0;
    int   n_err = 0;
    int   as_cnt = 0;
    int   as0;
    rec_t sb[$];
    rec_t nop;
    vec_t vt[10];

    always #5 clk = ~clk;

    always @(posedge clk) if (bus_as) as_cnt <= as_cnt + 1;

    stage_mem dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .ex_pc(ex_pc), .ex_en(ex_en), .ex_br_flag(ex_br_flag), .ex_mem_op(ex_mem_op),
        .ex_mem_wr_data(ex_mem_wr_data), .ex_ctrl_op(ex_ctrl_op), .ex_dst_addr(ex_dst_addr),
        .ex_gpr_we_(ex_gpr_we_), .ex_exp_code(ex_exp_code), .ex_out(ex_out),
        .bus_req(bus_req), .bus_grant(bus_grant), .bus_as(bus_as), .bus_rw(bus_rw),
        .bus_addr(bus_addr), .bus_wr_data(bus_wr_data), .bus_rd_data(bus_rd_data),
        .bus_rdy(bus_rdy), .busy(busy), .fwd_data(fwd_data),
        .mem_pc(mem_pc), .mem_en(mem_en), .mem_br_flag(mem_br_flag),
        .mem_ctrl_op(mem_ctrl_op), .mem_dst_addr(mem_dst_addr), .mem_gpr_we_(mem_gpr_we_),
        .mem_exp_code(mem_exp_code), .mem_out(mem_out)
    );

    function automatic rec_t mk_rec(input logic [29:0] pc, input logic en, input logic br,
                                    input logic [1:0] ctrl, input logic [4:0] dst,
                                    input logic we_, input logic [2:0] exp,
                                    input logic [31:0] out);
        rec_t r;
        r.pc = pc; r.en = en; r.br = br; r.ctrl = ctrl; r.dst = dst;
        r.we_ = we_; r.exp = exp; r.out = out;
        return r;
    endfunction

    function automatic vec_t mk_vec(input logic [29:0] pc, input logic en, input logic br,
                                    input logic [1:0] op, input logic [1:0] ctrl,
                                    input logic [4:0] dst, input logic we_,
                                    input logic [2:0] ec, input logic [31:0] a,
                                    input logic fl, input logic st, input rec_t e,
                                    input logic eb);
        vec_t v;
        v.pc = pc; v.en = en; v.br = br; v.op = op; v.ctrl = ctrl; v.dst = dst;
        v.we_ = we_; v.ec = ec; v.a = a; v.fl = fl; v.st = st; v.e = e; v.ebusy = eb;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_rec(input string name);
        rec_t e, a;
        n_chk++;
        a = {mem_pc, mem_en, mem_br_flag, mem_ctrl_op, mem_dst_addr, mem_gpr_we_,
             mem_exp_code, mem_out};
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL %s: scoreboard empty, got record %h", name, a);
        end else begin
            e = sb.pop_front();
            if (a !== e) begin
                n_err++;
                $display("FAIL %s: got record %h expected %h (out %h vs %h)", name, a, e,
                         a.out, e.out);
            end
        end
    endtask

    task automatic set_ex(input logic [29:0] pc, input logic en, input logic br,
                          input logic [1:0] op, input logic [31:0] wd, input logic [1:0] ctrl,
                          input logic [4:0] dst, input logic we_, input logic [2:0] ec,
                          input logic [31:0] a);
        ex_pc = pc; ex_en = en; ex_br_flag = br; ex_mem_op = op; ex_mem_wr_data = wd;
        ex_ctrl_op = ctrl; ex_dst_addr = dst; ex_gpr_we_ = we_; ex_exp_code = ec; ex_out = a;
    endtask

    // Empty slot with the register held, so nothing loads between sequences.
    task automatic bubble();
        set_ex(30'd0, 1'b0, 1'b0, 2'd0, 32'd0, 2'd0, 5'd0, 1'b1, 3'd0, 32'd0);
        stall = 1'b1; flush = 1'b0; bus_grant = 1'b0; bus_rdy = 1'b0; bus_rd_data = '0;
    endtask

    initial begin
        reset = 1'b1;
        bubble();
        stall = 1'b0;
        nop = mk_rec(30'd0, 1'b0, 1'b0, 2'd0, 5'd0, 1'b1, 3'd0, 32'd0);

        vt[0] = mk_vec(30'h10, 1, 0, 2'd0, 2'd1, 5'd3, 0, 3'd0, 32'h1234, 0, 0,
                       mk_rec(30'h10, 1, 0, 2'd1, 5'd3, 0, 3'd0, 32'h1234), 0);
        vt[1] = mk_vec(30'h11, 1, 1, 2'd2, 2'd2, 5'd5, 0, 3'd0, 32'h203, 0, 0,
                       mk_rec(30'h11, 1, 1, 2'd0, 5'd0, 1, 3'd4, 32'h0), 0);
        vt[2] = mk_vec(30'h12, 1, 0, 2'd1, 2'd1, 5'd6, 0, 3'd0, 32'h101, 0, 0,
                       mk_rec(30'h12, 1, 0, 2'd0, 5'd0, 1, 3'd4, 32'h0), 0);
        vt[3] = mk_vec(30'h13, 1, 1, 2'd0, 2'd3, 5'd7, 0, 3'd0, 32'hAAAA, 1, 0, nop, 0);
        vt[4] = mk_vec(30'h14, 1, 0, 2'd0, 2'd1, 5'd8, 0, 3'd0, 32'h5555, 0, 1, nop, 0);
        vt[5] = mk_vec(30'h15, 1, 0, 2'd1, 2'd2, 5'd9, 0, 3'd2, 32'h800, 0, 0,
                       mk_rec(30'h15, 1, 0, 2'd2, 5'd9, 0, 3'd2, 32'h800), 0);
        vt[6] = mk_vec(30'h16, 0, 1, 2'd1, 2'd1, 5'd10, 0, 3'd0, 32'h900, 0, 0,
                       mk_rec(30'h16, 0, 1, 2'd1, 5'd10, 0, 3'd0, 32'h900), 0);
        vt[7] = mk_vec(30'h17, 1, 0, 2'd3, 2'd0, 5'd11, 0, 3'd0, 32'hA00, 0, 0,
                       mk_rec(30'h17, 1, 0, 2'd0, 5'd11, 0, 3'd0, 32'hA00), 0);
        vt[8] = mk_vec(30'h18, 1, 0, 2'd2, 2'd1, 5'd12, 0, 3'd0, 32'h202, 1, 0, nop, 0);
        vt[9] = mk_vec(30'h19, 1, 0, 2'd0, 2'd2, 5'd13, 1, 3'd5, 32'h7, 0, 1, nop, 0);

        // Reset state
        @(negedge clk);
        @(negedge clk);
        sb.push_back(nop);
        chk_rec("reset_rec");
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_req", {31'd0, bus_req}, 32'd0);
        reset = 1'b0;

        // Single-cycle vectors
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            set_ex(vt[i].pc, vt[i].en, vt[i].br, vt[i].op, 32'h0, vt[i].ctrl, vt[i].dst,
                   vt[i].we_, vt[i].ec, vt[i].a);
            flush = vt[i].fl; stall = vt[i].st;
            sb.push_back(vt[i].e);
            #1;
            chk($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, vt[i].ebusy});
            chk($sformatf("vec%0d_req", i), {31'd0, bus_req}, 32'd0);
            chk($sformatf("vec%0d_fwd", i), fwd_data, vt[i].e.out);
            @(posedge clk); #1;
            chk_rec($sformatf("vec%0d_rec", i));
        end

        // Load, grant on the second REQ cycle, rdy right after ACCESS
        @(negedge clk);
        bubble(); stall = 1'b0;
        set_ex(30'h20, 1, 0, 2'd1, 32'h0, 2'd1, 5'd7, 0, 3'd0, 32'h100);
        sb.push_back(mk_rec(30'h20, 1, 0, 2'd1, 5'd7, 0, 3'd0, 32'hDEADBEEF));
        as0 = as_cnt;
        #1 chk("ld_idle_busy", {31'd0, busy}, 32'd1);
        chk("ld_idle_req", {31'd0, bus_req}, 32'd0);
        @(negedge clk);
        chk("ld_req1", {30'd0, bus_req, bus_as}, 32'b10);
        @(negedge clk);
        bus_grant = 1'b1;
        #1 chk("ld_req2_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        bus_grant = 1'b0;
        chk("ld_as", {31'd0, bus_as}, 32'd1);
        chk("ld_addr", {2'd0, bus_addr}, 32'h40);
        chk("ld_rw", {31'd0, bus_rw}, 32'd1);
        chk("ld_acc_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("ld_wait", {29'd0, bus_as, bus_req, busy}, 32'b011);
        bus_rdy = 1'b1; bus_rd_data = 32'hDEADBEEF;
        #1 chk("ld_rdy_busy", {31'd0, busy}, 32'd0);
        chk("ld_fwd", fwd_data, 32'hDEADBEEF);
        @(posedge clk); #1;
        chk_rec("ld_rec");
        chk("ld_as_pulses", as_cnt - as0, 32'd1);

        // Aligned store, grant and rdy immediate
        @(negedge clk);
        bubble(); stall = 1'b0; bus_grant = 1'b1;
        set_ex(30'h30, 1, 0, 2'd2, 32'h55AA55AA, 2'd3, 5'd9, 1, 3'd0, 32'h200);
        sb.push_back(mk_rec(30'h30, 1, 0, 2'd3, 5'd9, 1, 3'd0, 32'h200));
        @(negedge clk);
        @(negedge clk);
        chk("st_rw", {31'd0, bus_rw}, 32'd0);
        chk("st_wdata", bus_wr_data, 32'h55AA55AA);
        chk("st_addr", {2'd0, bus_addr}, 32'h80);
        @(negedge clk);
        bus_grant = 1'b0; bus_rdy = 1'b1; bus_rd_data = 32'h99;
        #1 chk("st_fwd", fwd_data, 32'h200);
        @(posedge clk); #1;
        chk_rec("st_rec");

        // Load with stall high at rdy: parks in DONE until stall drops
        @(negedge clk);
        bubble(); stall = 1'b0; bus_grant = 1'b1;
        set_ex(30'h40, 1, 0, 2'd1, 32'h0, 2'd0, 5'd2, 0, 3'd0, 32'h104);
        sb.push_back(mk_rec(30'h40, 1, 0, 2'd0, 5'd2, 0, 3'd0, 32'hCAFEF00D));
        @(negedge clk);
        @(negedge clk);
        chk("dn_addr", {2'd0, bus_addr}, 32'h41);
        @(negedge clk);
        bus_grant = 1'b0; bus_rdy = 1'b1; bus_rd_data = 32'hCAFEF00D; stall = 1'b1;
        @(posedge clk); #1;
        chk("dn_hold1", mem_out, 32'h200);
        @(negedge clk);
        bus_rdy = 1'b0; bus_rd_data = 32'h0;
        #1 chk("dn_req", {30'd0, bus_req, busy}, 32'b00);
        @(posedge clk); #1;
        chk("dn_hold2", mem_out, 32'h200);
        @(negedge clk);
        stall = 1'b0;
        #1 chk("dn_fwd", fwd_data, 32'hCAFEF00D);
        @(posedge clk); #1;
        chk_rec("dn_rec");

        // Flush while in REQ
        @(negedge clk);
        bubble(); stall = 1'b0;
        set_ex(30'h50, 1, 0, 2'd1, 32'h0, 2'd1, 5'd4, 0, 3'd0, 32'h300);
        sb.push_back(nop);
        @(negedge clk);
        chk("frq_req_on", {31'd0, bus_req}, 32'd1);
        flush = 1'b1;
        #1 chk("frq_req_drop", {30'd0, bus_req, busy}, 32'b00);
        chk("frq_fwd", fwd_data, 32'h0);
        @(posedge clk); #1;
        chk_rec("frq_rec");
        @(negedge clk);
        bubble();
        #1 chk("frq_idle", {31'd0, bus_req}, 32'd0);

        // Flush while in WAIT: bus still completes, result discarded
        @(negedge clk);
        bubble(); stall = 1'b0; bus_grant = 1'b1;
        set_ex(30'h60, 1, 1, 2'd1, 32'h0, 2'd2, 5'd6, 0, 3'd0, 32'h400);
        sb.push_back(nop);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        bus_grant = 1'b0; flush = 1'b1;
        #1 chk("fwt_req_kept", {31'd0, bus_req}, 32'd1);
        @(negedge clk);
        flush = 1'b0;
        #1 chk("fwt_still", {30'd0, bus_req, busy}, 32'b11);
        bus_rdy = 1'b1; bus_rd_data = 32'h1111;
        #1 chk("fwt_rdy_busy", {31'd0, busy}, 32'd0);
        chk("fwt_fwd", fwd_data, 32'h0);
        @(posedge clk); #1;
        chk_rec("fwt_rec");

        // ALU op, then reset in the middle of a load's WAIT
        @(negedge clk);
        bubble(); stall = 1'b0;
        set_ex(30'h68, 1, 1, 2'd0, 32'h0, 2'd3, 5'd31, 0, 3'd1, 32'h1234);
        sb.push_back(mk_rec(30'h68, 1, 1, 2'd3, 5'd31, 0, 3'd1, 32'h1234));
        @(posedge clk); #1;
        chk_rec("rst_pre_rec");
        @(negedge clk);
        bus_grant = 1'b1;
        set_ex(30'h6C, 1, 0, 2'd1, 32'h0, 2'd1, 5'd1, 0, 3'd0, 32'h500);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_wait", {31'd0, bus_req}, 32'd1);
        bubble();
        reset = 1'b1;
        sb.push_back(nop);
        @(posedge clk); #1;
        chk_rec("rst_rec");
        chk("rst_outs", {29'd0, bus_req, bus_as, busy}, 32'd0);
        @(negedge clk);
        reset = 1'b0; stall = 1'b0;
        set_ex(30'h70, 1, 0, 2'd0, 32'h0, 2'd0, 5'd3, 0, 3'd0, 32'h77);
        sb.push_back(mk_rec(30'h70, 1, 0, 2'd0, 5'd3, 0, 3'd0, 32'h77));
        #1 chk("rst_idle_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        chk_rec("rst_post_rec");

        chk("sb_drained", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
